// File: rtl/chirp_waveform_responder.sv
// -----------------------------------------------------------------------------
// chirp_waveform_responder
//
// Chirp-side responder to the radar pulse controller's chirp handshake. When
// ready and chirp_init arrives with chirp_enable high, the chirp configuration
// is latched and a linear-FM chirp is streamed out as phase/frequency words
// from a quadratic phase accumulator (frequency ramps by a constant step each
// sample, phase integrates frequency). The stream uses valid/ready handshaking
// so the downstream DDS/DAC path can apply backpressure.
//
// Ports:
//   aclk, areset             clock, synchronous active-high reset
//   chirp_init               single-cycle start request
//   chirp_enable             level, must stay high for the whole pulse
//   chirp_ready              high while a start request will be accepted
//   chirp_active             high while samples are being generated
//   chirp_done               one-cycle pulse on normal completion
//   chirp_aborted            one-cycle pulse when chirp_enable drops mid-pulse
//   chirp_counter_max        chirp length in samples (latched on accept)
//   chirp_freq_offset        start frequency word f0 (latched on accept)
//   chirp_tuning_word_coeff  signed per-sample frequency increment
//   out_phase, out_freq      current sample's phase and frequency words
//   out_tvalid, out_tlast    stream valid and final-sample marker
//   out_tready               downstream accept
// -----------------------------------------------------------------------------
module chirp_waveform_responder #(
    parameter int PHASE_W       = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int GUARD_CYCLES  = 4
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               chirp_init,
    input  logic               chirp_enable,
    output logic               chirp_ready,
    output logic               chirp_active,
    output logic               chirp_done,
    output logic               chirp_aborted,
    input  logic [31:0]        chirp_counter_max,
    input  logic [PHASE_W-1:0] chirp_freq_offset,
    input  logic [PHASE_W-1:0] chirp_tuning_word_coeff,
    output logic [PHASE_W-1:0] out_phase,
    output logic [PHASE_W-1:0] out_freq,
    output logic               out_tvalid,
    output logic               out_tlast,
    input  logic               out_tready
);

    localparam logic [2:0] ST_SETTLE  = 3'd0;
    localparam logic [2:0] ST_READY   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ABORT   = 3'd4;
    localparam logic [2:0] ST_HOLDOFF = 3'd5;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GUARD_LAST  = 16'(GUARD_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [15:0]        tmr_q, tmr_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        len_q, len_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic               last_sample;

    assign last_sample = (cnt_q == len_q - 32'd1);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        phase_d = phase_q;
        freq_d  = freq_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        step_d  = step_q;
        case (state_q)
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_READY;
                    tmr_d   = 16'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_READY: begin
                if (chirp_init && chirp_enable) begin
                    len_d   = chirp_counter_max;
                    step_d  = chirp_tuning_word_coeff;
                    phase_d = '0;
                    freq_d  = chirp_freq_offset;
                    cnt_d   = 32'd0;
                    // A zero-length chirp still reports completion.
                    state_d = (chirp_counter_max != 32'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // Abort wins over a simultaneous final beat, and that beat
                // does not advance the accumulators.
                if (!chirp_enable) begin
                    state_d = ST_ABORT;
                end else if (out_tready) begin
                    phase_d = phase_q + freq_q;
                    freq_d  = freq_q + step_q;
                    cnt_d   = cnt_q + 32'd1;
                    if (last_sample) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ABORT: begin
                state_d = ST_HOLDOFF;
                tmr_d   = 16'd0;
            end
            ST_HOLDOFF: begin
                if (tmr_q == GUARD_LAST) begin
                    state_d = ST_READY;
                    tmr_d   = 16'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                tmr_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_SETTLE;
            tmr_q   <= 16'd0;
            phase_q <= '0;
            freq_q  <= '0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            phase_q <= phase_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Configuration is only meaningful while a chirp is in flight, so it
    // carries no reset.
    always_ff @(posedge aclk) begin
        len_q  <= len_d;
        step_q <= step_d;
    end

    // All outputs decode straight from registered state and counters.
    assign chirp_ready   = (state_q == ST_READY);
    assign chirp_active  = (state_q == ST_RUN);
    assign chirp_done    = (state_q == ST_DONE);
    assign chirp_aborted = (state_q == ST_ABORT);
    assign out_tvalid    = (state_q == ST_RUN);
    assign out_tlast     = (state_q == ST_RUN) && last_sample;
    assign out_phase     = phase_q;
    assign out_freq      = freq_q;

endmodule

// File: tb/tb_chirp_waveform_responder.sv
module tb_chirp_waveform_responder;

    localparam int PHASE_W = 32;
    localparam int SETTLE  = 16;
    localparam int GUARD   = 4;

    logic               aclk = 1'b0;
    logic               areset;
    logic               chirp_init;
    logic               chirp_enable;
    logic               chirp_ready;
    logic               chirp_active;
    logic               chirp_done;
    logic               chirp_aborted;
    logic [31:0]        chirp_counter_max;
    logic [PHASE_W-1:0] chirp_freq_offset;
    logic [PHASE_W-1:0] chirp_tuning_word_coeff;
    logic [PHASE_W-1:0] out_phase;
    logic [PHASE_W-1:0] out_freq;
    logic               out_tvalid;
    logic               out_tlast;
    logic               out_tready;

    int n_chk  = 0;
    int n_pass = 0;

    chirp_waveform_responder #(
        .PHASE_W(PHASE_W), .SETTLE_CYCLES(SETTLE), .GUARD_CYCLES(GUARD)
    ) dut (
        .aclk(aclk), .areset(areset),
        .chirp_init(chirp_init), .chirp_enable(chirp_enable),
        .chirp_ready(chirp_ready), .chirp_active(chirp_active),
        .chirp_done(chirp_done), .chirp_aborted(chirp_aborted),
        .chirp_counter_max(chirp_counter_max),
        .chirp_freq_offset(chirp_freq_offset),
        .chirp_tuning_word_coeff(chirp_tuning_word_coeff),
        .out_phase(out_phase), .out_freq(out_freq),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .out_tready(out_tready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: inputs set at the falling edge take effect at the next
    // rising edge; outputs are then observed at the following falling edge.
    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Closed-form sample k: freq = f0 + k*step,
    // phase = sum of earlier freqs = k*f0 + step*k*(k-1)/2  (mod 2^32).
    function automatic logic [31:0] m_freq(logic [31:0] f0, logic [31:0] st, int unsigned k);
        logic [31:0] kk;
        kk = k;
        return f0 + kk * st;
    endfunction

    function automatic logic [31:0] m_phase(logic [31:0] f0, logic [31:0] st, int unsigned k);
        logic [31:0] kk, tri_n;
        kk    = k;
        tri_n = (k * (k - 1)) / 2;
        return kk * f0 + tri_n * st;
    endfunction

    task automatic wait_settle(input int inject_init);
        int n;
        n = 0;
        while (!chirp_ready && n < 100) begin
            if (inject_init != 0 && n == 3) begin
                chirp_init   = 1'b1;
                chirp_enable = 1'b1;
            end else begin
                chirp_init   = 1'b0;
                chirp_enable = 1'b0;
            end
            tick();
            n++;
            if (!chirp_ready) chk("settle_active", chirp_active, 1'b0);
        end
        chirp_init   = 1'b0;
        chirp_enable = 1'b0;
        chk("settle_cycles", n, SETTLE);
        chk("settle_active_at_ready", chirp_active, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, chirp_ready, 1'b0);
        chk({tag, "_active"}, chirp_active, 1'b0);
        chk({tag, "_done"}, chirp_done, 1'b0);
        chk({tag, "_aborted"}, chirp_aborted, 1'b0);
        chk({tag, "_tvalid"}, out_tvalid, 1'b0);
        chk({tag, "_tlast"}, out_tlast, 1'b0);
        chk({tag, "_phase"}, out_phase, 32'd0);
        chk({tag, "_freq"}, out_freq, 32'd0);
    endtask

    // mode: 0 = tready always 1, 1 = pattern 1,0,0 repeating, 2 = random.
    // abort_at >= 0 drops chirp_enable once that many beats have completed.
    task automatic run_chirp(input int unsigned len, input logic [31:0] f0,
                             input logic [31:0] st, input int mode, input int abort_at);
        int unsigned beats;
        int   cyc;
        int   n;
        int   ends;
        bit   ended;
        bit   was_abort;
        logic tr;
        beats = 0; cyc = 0; ended = 1'b0; was_abort = 1'b0;

        n = 0;
        while (!chirp_ready && n < 50) begin tick(); n++; end
        chk("ready_before_init", chirp_ready, 1'b1);

        chirp_init              = 1'b1;
        chirp_enable            = 1'b1;
        chirp_counter_max       = len;
        chirp_freq_offset       = f0;
        chirp_tuning_word_coeff = st;
        out_tready              = 1'b1;
        tick();
        chirp_init              = 1'b0;
        // Config outside the accept cycle must not matter.
        chirp_counter_max       = $urandom;
        chirp_freq_offset       = $urandom;
        chirp_tuning_word_coeff = $urandom;
        chk("ready_after_accept", chirp_ready, 1'b0);

        if (len == 0) begin
            chk("l0_done", chirp_done, 1'b1);
            chk("l0_tvalid", out_tvalid, 1'b0);
            chk("l0_aborted", chirp_aborted, 1'b0);
        end else begin
            while (!ended && cyc < 300) begin
                chk("tvalid", out_tvalid, 1'b1);
                chk("active", chirp_active, 1'b1);
                chk("phase", out_phase, m_phase(f0, st, beats));
                chk("freq", out_freq, m_freq(f0, st, beats));
                chk("tlast", out_tlast, (beats == len - 1));
                chk("done_in_run", chirp_done, 1'b0);
                case (mode)
                    0:       tr = 1'b1;
                    1:       tr = (cyc % 3 == 0);
                    default: tr = $urandom_range(0, 1) != 0;
                endcase
                out_tready = tr;
                if (abort_at >= 0 && beats == abort_at) chirp_enable = 1'b0;
                tick();
                cyc++;
                if (!chirp_enable) begin
                    ended = 1'b1;
                    was_abort = 1'b1;
                end else if (tr) begin
                    beats++;
                    if (beats == len) ended = 1'b1;
                end
            end
            chk("run_finished_in_budget", ended, 1'b1);
            chk("end_done", chirp_done, !was_abort);
            chk("end_aborted", chirp_aborted, was_abort);
            chk("end_tvalid", out_tvalid, 1'b0);
            chk("end_active", chirp_active, 1'b0);
            chk("beat_count", beats, was_abort ? abort_at : len);
        end

        chirp_enable = 1'b0;
        out_tready   = 1'b1;
        n = 0;
        ends = 0;
        while (!chirp_ready && n < 50) begin
            tick();
            n++;
            if (chirp_done || chirp_aborted || out_tvalid) ends++;
        end
        chk("extra_end_pulses", ends, 0);
        chk("guard_cycles", n, GUARD + 1);
    endtask

    initial begin
        int unsigned rl;
        int ab;
        areset                  = 1'b1;
        chirp_init              = 1'b0;
        chirp_enable            = 1'b0;
        chirp_counter_max       = '0;
        chirp_freq_offset       = '0;
        chirp_tuning_word_coeff = '0;
        out_tready              = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        check_all_zero("reset");
        wait_settle(1);

        // Basic, backpressured, and wrapping/negative-step chirps.
        run_chirp(4, 32'h100, 32'h10, 0, -1);
        run_chirp(4, 32'h100, 32'h10, 1, -1);
        run_chirp(3, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, -1);

        // Abort after two beats of a ten-sample chirp, then zero length.
        run_chirp(10, 32'h1234, 32'h55, 0, 2);
        run_chirp(0, 32'h777, 32'h1, 0, -1);

        // Init without enable while ready is ignored.
        chirp_init   = 1'b1;
        chirp_enable = 1'b0;
        tick();
        chirp_init = 1'b0;
        chk("gated_init_ready", chirp_ready, 1'b1);
        chk("gated_init_active", chirp_active, 1'b0);
        tick();
        chk("gated_init_tvalid", out_tvalid, 1'b0);

        // Reset during the third sample of a running chirp.
        chirp_init              = 1'b1;
        chirp_enable            = 1'b1;
        chirp_counter_max       = 6;
        chirp_freq_offset       = 32'h40;
        chirp_tuning_word_coeff = 32'h4;
        out_tready              = 1'b1;
        tick();
        chirp_init = 1'b0;
        tick();
        tick();
        chk("pre_reset_phase", out_phase, m_phase(32'h40, 32'h4, 2));
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chirp_enable = 1'b0;
        check_all_zero("midrun_reset");
        wait_settle(0);

        // Randomized chirps against the closed-form model.
        for (int i = 0; i < 8; i++) begin
            rl = $urandom_range(1, 12);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
            run_chirp(rl, $urandom, $urandom, 2, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
